// File: rtl/next_pc_unit_if.sv
// Program-counter producer bus: pipeline inputs and next-PC/control outputs.
interface next_pc_unit_if #(
    parameter int NBITS    = 32,
    parameter int CNT_BITS = 32
);
    logic [NBITS-1:0]    i_PC;
    logic [NBITS-1:0]    i_PC_4;
    logic [NBITS-1:0]    i_instr;
    logic                i_start;
    logic                i_mode_step;
    logic                i_step;
    logic                i_stall;
    logic                i_branch_taken;
    logic [NBITS-1:0]    i_branch_target;
    logic                i_jr;
    logic [NBITS-1:0]    i_jr_target;
    logic                i_jump;
    logic [NBITS-1:0]    i_jump_target;
    logic [NBITS-1:0]    o_NPC;
    logic                o_flush;
    logic                o_halted;
    logic [1:0]          o_state;
    logic [CNT_BITS-1:0] o_cycle_count;

    modport slave (
        input  i_PC, i_PC_4, i_instr, i_start, i_mode_step, i_step,
        input  i_stall, i_branch_taken, i_branch_target,
        input  i_jr, i_jr_target, i_jump, i_jump_target,
        output o_NPC, o_flush, o_halted, o_state, o_cycle_count
    );

    modport master (
        output i_PC, i_PC_4, i_instr, i_start, i_mode_step, i_step,
        output i_stall, i_branch_taken, i_branch_target,
        output i_jr, i_jr_target, i_jump, i_jump_target,
        input  o_NPC, o_flush, o_halted, o_state, o_cycle_count
    );
endinterface

// File: rtl/next_pc_unit.sv
// Next-PC selection with stall-held redirects, run/step/halt control
// and a saturating active-cycle counter.
module next_pc_unit #(
    parameter int               NBITS      = 32,
    parameter logic [NBITS-1:0] HALT_INSTR = 32'hFFFFFFFF,
    parameter int               CNT_BITS   = 32
) (
    input  logic           i_clk,
    input  logic           i_reset,
    next_pc_unit_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic                pend_valid_q, pend_valid_d;
    logic [NBITS-1:0]    pend_addr_q, pend_addr_d;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;

    logic             adv;
    logic             redir_any;
    logic [NBITS-1:0] live_tgt;
    logic [NBITS-1:0] npc;
    logic             flush;

    // Branch wins: it belongs to the oldest instruction in flight.
    always_comb begin
        redir_any = bus.i_branch_taken | bus.i_jr | bus.i_jump;
        if (bus.i_branch_taken) begin
            live_tgt = bus.i_branch_target;
        end else if (bus.i_jr) begin
            live_tgt = bus.i_jr_target;
        end else begin
            live_tgt = bus.i_jump_target;
        end
        adv = (state_q == RUN) || ((state_q == STEP) && bus.i_step);
    end

    always_comb begin
        state_d      = state_q;
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        cnt_d        = cnt_q;
        npc          = bus.i_PC;
        flush        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = bus.i_mode_step ? STEP : RUN;
                end
            end
            RUN, STEP: begin
                if (adv && !bus.i_stall) begin
                    if (pend_valid_q) begin
                        npc          = pend_addr_q;
                        flush        = 1'b1;
                        pend_valid_d = 1'b0;
                    end else if (redir_any) begin
                        npc   = live_tgt;
                        flush = 1'b1;
                    end else if (bus.i_instr == HALT_INSTR) begin
                        state_d      = HALT;
                        pend_valid_d = 1'b0;
                    end else begin
                        npc = bus.i_PC_4;
                    end
                end else if (redir_any) begin
                    // A held jump/jr never displaces an older pending target.
                    if (!pend_valid_q) begin
                        pend_valid_d = 1'b1;
                        pend_addr_d  = live_tgt;
                    end else if (bus.i_branch_taken) begin
                        pend_addr_d = bus.i_branch_target;
                    end
                end
                if (adv && !(&cnt_q)) begin
                    cnt_d = cnt_q + {{(CNT_BITS-1){1'b0}}, 1'b1};
                end
            end
            HALT: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= IDLE;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.o_NPC         = npc;
    assign bus.o_flush       = flush;
    assign bus.o_halted      = (state_q == HALT);
    assign bus.o_state       = state_q;
    assign bus.o_cycle_count = cnt_q;
endmodule

// File: tb/tb_next_pc_unit.sv
// Scoreboard bench for next_pc_unit: directed scenarios, then random
// traffic checked against a behavioural model.
module tb_next_pc_unit;
    localparam int CW = 6;

    typedef struct {
        logic [31:0]   npc;
        logic          flush;
        logic          halted;
        logic [1:0]    state;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    next_pc_unit_if #(.NBITS(32), .CNT_BITS(CW)) ifc ();

    next_pc_unit #(
        .NBITS(32),
        .HALT_INSTR(32'hFFFFFFFF),
        .CNT_BITS(CW)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .bus(ifc.slave)
    );

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: 0 idle, 1 run, 2 step, 3 halt
    int          m_st;
    bit          m_pv;
    logic [31:0] m_pa;
    int          m_cnt;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("npc", ifc.o_NPC, e.npc);
                chk("flush", {31'b0, ifc.o_flush}, {31'b0, e.flush});
                chk("halted", {31'b0, ifc.o_halted}, {31'b0, e.halted});
                chk("state", {30'b0, ifc.o_state}, {30'b0, e.state});
                chk("count", {{(32-CW){1'b0}}, ifc.o_cycle_count},
                    {{(32-CW){1'b0}}, e.cnt});
            end
        end
    end

    task automatic clr_in();
        ifc.i_start = 0; ifc.i_mode_step = 0; ifc.i_step = 0;
        ifc.i_stall = 0; ifc.i_branch_taken = 0; ifc.i_jr = 0;
        ifc.i_jump = 0; ifc.i_instr = 32'h00000013;
        ifc.i_branch_target = 0; ifc.i_jr_target = 0; ifc.i_jump_target = 0;
    endtask

    task automatic set_pc(input logic [31:0] pc);
        ifc.i_PC = pc;
        ifc.i_PC_4 = pc + 32'd4;
    endtask

    // Computes expected outputs for the current inputs, queues them,
    // then advances the model across one clock edge.
    task automatic tick(output logic [31:0] npc_o);
        exp_t e;
        bit adv, any, halting;
        logic [31:0] tgt;
        int nst, ncnt;
        bit npv;
        logic [31:0] npa;
        any = ifc.i_branch_taken || ifc.i_jr || ifc.i_jump;
        tgt = ifc.i_branch_taken ? ifc.i_branch_target :
              ifc.i_jr ? ifc.i_jr_target : ifc.i_jump_target;
        adv = (m_st == 1) || (m_st == 2 && ifc.i_step);
        e.npc = ifc.i_PC; e.flush = 0;
        e.halted = (m_st == 3); e.state = 2'(m_st); e.cnt = CW'(m_cnt);
        nst = m_st; npv = m_pv; npa = m_pa; ncnt = m_cnt;
        halting = 0;
        if (m_st == 0 && ifc.i_start) nst = ifc.i_mode_step ? 2 : 1;
        if (adv && !ifc.i_stall) begin
            if (m_pv) begin
                e.npc = m_pa; e.flush = 1; npv = 0;
            end else if (any) begin
                e.npc = tgt; e.flush = 1;
            end else if (ifc.i_instr == 32'hFFFFFFFF) begin
                halting = 1;
            end else begin
                e.npc = ifc.i_PC + 32'd4;
            end
        end else if ((m_st == 1 || m_st == 2) && any) begin
            if (!m_pv) begin npv = 1; npa = tgt; end
            else if (ifc.i_branch_taken) npa = ifc.i_branch_target;
        end
        if (halting) begin nst = 3; npv = 0; end
        if (adv && m_cnt < (1 << CW) - 1) ncnt = m_cnt + 1;
        if (rst) begin nst = 0; npv = 0; npa = 0; ncnt = 0; end
        q.push_back(e);
        npc_o = e.npc;
        @(posedge clk);
        #1;
        m_st = nst; m_pv = npv; m_pa = npa; m_cnt = ncnt;
    endtask

    task automatic do_reset();
        logic [31:0] d;
        rst = 1;
        tick(d);
        rst = 0;
    endtask

    initial begin
        logic [31:0] npc;
        clr_in();
        set_pc(0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        m_st = 0; m_pv = 0; m_pa = 0; m_cnt = 0;
        do_reset();

        // Continuous run from PC 0
        ifc.i_start = 1;
        tick(npc);
        clr_in();
        for (int i = 0; i < 4; i++) begin
            tick(npc);
            set_pc(npc);
        end

        // Branch beats jump in the same cycle
        set_pc(32'h20);
        ifc.i_branch_taken = 1; ifc.i_branch_target = 32'h100;
        ifc.i_jump = 1; ifc.i_jump_target = 32'h200;
        tick(npc);
        clr_in(); set_pc(npc);
        tick(npc);

        // Jump held across stall, replaced by a later branch
        set_pc(32'h24);
        ifc.i_stall = 1; ifc.i_jump = 1; ifc.i_jump_target = 32'h40;
        tick(npc); tick(npc);
        clr_in();
        ifc.i_stall = 1; ifc.i_branch_taken = 1; ifc.i_branch_target = 32'h80;
        tick(npc);
        clr_in();
        tick(npc);
        set_pc(npc);
        tick(npc);

        // Step mode
        do_reset();
        set_pc(32'h8);
        ifc.i_start = 1; ifc.i_mode_step = 1;
        tick(npc);
        clr_in();
        for (int i = 0; i < 5; i++) tick(npc);
        ifc.i_step = 1;
        tick(npc);
        clr_in(); set_pc(npc);
        tick(npc);

        // Halt, then start ignored
        do_reset();
        ifc.i_start = 1;
        tick(npc);
        clr_in();
        set_pc(32'h30); ifc.i_instr = 32'hFFFFFFFF;
        tick(npc);
        clr_in();
        ifc.i_start = 1;
        tick(npc); tick(npc);
        clr_in();

        // Redirect discards halt word
        do_reset();
        ifc.i_start = 1;
        tick(npc);
        clr_in();
        set_pc(32'h30); ifc.i_instr = 32'hFFFFFFFF;
        ifc.i_jump = 1; ifc.i_jump_target = 32'h10;
        tick(npc);
        clr_in(); set_pc(npc);
        tick(npc);

        // Reset while a pending jump waits behind a stall
        ifc.i_stall = 1; ifc.i_jump = 1; ifc.i_jump_target = 32'h40;
        tick(npc);
        rst = 1;
        tick(npc);
        rst = 0;
        tick(npc); tick(npc);
        clr_in();

        // Random traffic with PC following the expected next PC
        set_pc(0);
        for (int i = 0; i < 3000; i++) begin
            ifc.i_start = ($urandom_range(0, 19) == 0);
            ifc.i_mode_step = $urandom_range(0, 1);
            ifc.i_step = $urandom_range(0, 1);
            ifc.i_stall = ($urandom_range(0, 9) < 3);
            ifc.i_branch_taken = ($urandom_range(0, 9) == 0);
            ifc.i_jr = ($urandom_range(0, 11) == 0);
            ifc.i_jump = ($urandom_range(0, 11) == 0);
            ifc.i_branch_target = $urandom & 32'hFFFF_FFFC;
            ifc.i_jr_target = $urandom;
            ifc.i_jump_target = $urandom & 32'hFFFF_FFFC;
            ifc.i_instr = ($urandom_range(0, 39) == 0) ? 32'hFFFFFFFF : $urandom;
            rst = ($urandom_range(0, 149) == 0);
            tick(npc);
            set_pc(npc);
        end
        rst = 0;
        clr_in();

        @(negedge clk); #1;
        chk("drain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
